// File: rtl/ctl_sequencer.sv
// Fetch/decode sequencer upstream of the ALU: owns the PC, fetches instructions and memory operands.
// Optional single-step gating of FETCH is enabled by defining SEQ_STEP_EN (adds input step_i).
module ctl_sequencer #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef SEQ_STEP_EN
  input  logic              step_i,
`endif
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [15:0]       mem_rdata_i,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] acc_in_i,
  output logic [1:0]        ctl_dev_o,
  output logic [3:0]        ctl_opaddr_o,
  output logic [DATA_W-1:0] sys_data_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              halted_o
);

  typedef enum logic [2:0] {
    StFetch,
    StFwait,
    StDecode,
    StOprd,
    StOwait,
    StExec,
    StHalt
  } state_e;

  localparam logic [3:0] OpLda = 4'h8;
  localparam logic [3:0] OpSta = 4'h9;
  localparam logic [3:0] OpJmp = 4'hA;
  localparam logic [3:0] OpJz  = 4'hB;
  localparam logic [3:0] OpHlt = 4'hF;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [15:0]       ir_q;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [1:0]        ctl_dev_q;
  logic [3:0]        ctl_opaddr_q;
  logic [DATA_W-1:0] sys_data_q;
  logic              halted_q;

  logic [3:0]        op;
  logic              is_alu, is_lda, is_sta, needs_mem, fetch_go;
  logic [1:0]        exec_dev;
  logic [3:0]        exec_op;
  logic [ADDR_W+7:0] imm_addr_ext;
  logic [DATA_W+7:0] imm_data_ext;
  logic [DATA_W+15:0] rd_data_ext;
  logic [ADDR_W-1:0] imm_addr;
  logic [DATA_W-1:0] imm_data, rd_data;
  logic              unused_rsvd;

`ifdef SEQ_STEP_EN
  assign fetch_go = step_i;
`else
  assign fetch_go = 1'b1;
`endif

  // Reserved instruction bits [10:8] carry no meaning.
  assign unused_rsvd = ^ir_q[10:8];

  assign op        = ir_q[15:12];
  assign is_alu    = ~op[3];
  assign is_lda    = (op == OpLda);
  assign is_sta    = (op == OpSta);
  assign needs_mem = is_sta | ((is_alu | is_lda) & ir_q[11]);
  assign exec_dev  = is_alu ? 2'd1 : (is_lda ? 2'd2 : 2'd0);
  assign exec_op   = is_alu ? op : 4'h0;

  // Zero-extend then truncate so any ADDR_W / DATA_W works.
  assign imm_addr_ext = {{ADDR_W{1'b0}}, ir_q[7:0]};
  assign imm_data_ext = {{DATA_W{1'b0}}, ir_q[7:0]};
  assign rd_data_ext  = {{DATA_W{1'b0}}, mem_rdata_i};
  assign imm_addr     = imm_addr_ext[ADDR_W-1:0];
  assign imm_data     = imm_data_ext[DATA_W-1:0];
  assign rd_data      = rd_data_ext[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ctl_dev_q    <= 2'd0;
      ctl_opaddr_q <= 4'h0;
      sys_data_q   <= '0;
      halted_q     <= 1'b0;
    end else begin
      case (state_q)
        StFetch: begin
          if (fetch_go) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= pc_q;
            state_q    <= StFwait;
          end
        end
        StFwait: begin
          if (mem_ack_i) begin
            ir_q      <= mem_rdata_i;
            pc_q      <= pc_q + ADDR_W'(1);
            mem_req_q <= 1'b0;
            state_q   <= StDecode;
          end
        end
        StDecode: begin
          if (op == OpHlt) begin
            halted_q <= 1'b1;
            state_q  <= StHalt;
          end else if (needs_mem) begin
            state_q <= StOprd;
          end else begin
            // Outputs are registered, so the strobe is loaded on entry to EXEC.
            ctl_dev_q    <= exec_dev;
            ctl_opaddr_q <= exec_op;
            sys_data_q   <= (exec_dev != 2'd0) ? imm_data : '0;
            state_q      <= StExec;
          end
        end
        StOprd: begin
          mem_req_q   <= 1'b1;
          mem_we_q    <= is_sta;
          mem_addr_q  <= imm_addr;
          mem_wdata_q <= is_sta ? acc_in_i : '0;
          state_q     <= StOwait;
        end
        StOwait: begin
          if (mem_ack_i) begin
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            ctl_dev_q    <= exec_dev;
            ctl_opaddr_q <= exec_op;
            sys_data_q   <= (exec_dev != 2'd0) ? rd_data : '0;
            state_q      <= StExec;
          end
        end
        StExec: begin
          ctl_dev_q    <= 2'd0;
          ctl_opaddr_q <= 4'h0;
          sys_data_q   <= '0;
          if ((op == OpJmp) || ((op == OpJz) && (acc_in_i == '0))) begin
            pc_q <= imm_addr;
          end
          state_q <= StFetch;
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StFetch;
        end
      endcase
    end
  end

  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign ctl_dev_o    = ctl_dev_q;
  assign ctl_opaddr_o = ctl_opaddr_q;
  assign sys_data_o   = sys_data_q;
  assign pc_o         = pc_q;
  assign halted_o     = halted_q;

endmodule

// File: tb/tb_ctl_sequencer.sv
// Directed bench for ctl_sequencer: vector table of single instructions plus reset and halt sequences.
module tb_ctl_sequencer;

  logic        clk, rst_n;
  logic        mem_req, mem_we, mem_ack, halted;
  logic [7:0]  mem_addr, mem_wdata, acc_in, sys_data, pc;
  logic [15:0] mem_rdata;
  logic [1:0]  ctl_dev;
  logic [3:0]  ctl_opaddr;
`ifdef SEQ_STEP_EN
  logic        step;
`endif

  int checks = 0;
  int errors = 0;
  int wait_n = 0;
  logic [15:0] mem [256];

  ctl_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef SEQ_STEP_EN
    .step_i       (step),
`endif
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .mem_ack_i    (mem_ack),
    .acc_in_i     (acc_in),
    .ctl_dev_o    (ctl_dev),
    .ctl_opaddr_o (ctl_opaddr),
    .sys_data_o   (sys_data),
    .pc_o         (pc),
    .halted_o     (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder: acks after wait_n idle cycles of a held request, one cycle wide.
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = 0;
        mem_ack = 1'b0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (mem_req) begin
        if (cnt >= wait_n) begin
          mem_ack = 1'b1;
          mem_rdata = mem[mem_addr];
        end else begin
          cnt++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    string       name;
    logic [15:0] instr;
    logic [15:0] opnd;    // contents of mem[0x40]
    logic [7:0]  acc;
    int          wt;
    int          nreq;    // requests before the next fetch
    int          strobes;
    logic [1:0]  dev;
    logic [3:0]  op;
    logic        chk_op;
    logic [7:0]  data;
    logic [7:0]  oaddr;
    logic        owe;
    logic [7:0]  owdata;
    logic [7:0]  nxt;
    int          lat;     // first request rise to next fetch request rise
  } vec_t;

  vec_t vecs[12];

  task automatic run_vec(input vec_t v);
    int cyc, nrise, strobes, c0, lat;
    logic prev;
    logic [1:0] dev_s;
    logic [3:0] op_s;
    logic [7:0] data_s, oaddr_s, owdata_s, nxt_s;
    logic owe_s;
    cyc = 0; nrise = 0; strobes = 0; c0 = 0; lat = 0; prev = 1'b0;
    dev_s = '0; op_s = '0; data_s = '0; oaddr_s = '0; owdata_s = '0; nxt_s = '0; owe_s = 1'b0;
    mem[0] = v.instr;
    mem[8'h40] = v.opnd;
    acc_in = v.acc;
    wait_n = v.wt;
    do_reset();
    while (nrise < v.nreq + 1 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (mem_req && !prev) begin
        nrise++;
        if (nrise == 1) c0 = cyc;
        if (nrise == 2 && v.nreq == 2) begin
          oaddr_s = mem_addr; owe_s = mem_we; owdata_s = mem_wdata;
        end
        if (nrise == v.nreq + 1) begin
          nxt_s = mem_addr; lat = cyc - c0;
        end
      end
      if (ctl_dev != 2'd0) begin
        strobes++;
        dev_s = ctl_dev; op_s = ctl_opaddr; data_s = sys_data;
      end
      prev = mem_req;
    end
    chk({v.name, " reached next fetch"}, 32'(nrise == v.nreq + 1), 32'd1);
    chk({v.name, " strobe count"}, 32'(strobes), 32'(v.strobes));
    if (v.strobes != 0) begin
      chk({v.name, " ctl_dev"}, 32'(dev_s), 32'(v.dev));
      chk({v.name, " sys_data"}, 32'(data_s), 32'(v.data));
      if (v.chk_op) chk({v.name, " ctl_opaddr"}, 32'(op_s), 32'(v.op));
    end
    if (v.nreq == 2) begin
      chk({v.name, " operand addr"}, 32'(oaddr_s), 32'(v.oaddr));
      chk({v.name, " operand we"}, 32'(owe_s), 32'(v.owe));
      if (v.owe) chk({v.name, " operand wdata"}, 32'(owdata_s), 32'(v.owdata));
    end
    chk({v.name, " next fetch addr"}, 32'(nxt_s), 32'(v.nxt));
    chk({v.name, " latency"}, 32'(lat), 32'(v.lat));
  endtask

  initial begin
    int nrise, cyc;
    logic prev;
    logic [7:0] addr2;
    rst_n = 1'b0;
    acc_in = '0;
`ifdef SEQ_STEP_EN
    step = 1'b1;
`endif
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

    //          name    instr     opnd      acc    wt nrq stb dev op    cop data   oaddr  owe   owdata nxt    lat
    vecs[0]  = '{"add_imm", 16'h0005, 16'h0000, 8'h00, 0, 1, 1, 2'd1, 4'h0, 1'b1, 8'h05, 8'h00, 1'b0, 8'h00, 8'h01, 4};
    vecs[1]  = '{"sub_mem", 16'h1840, 16'h0003, 8'h00, 2, 2, 1, 2'd1, 4'h1, 1'b1, 8'h03, 8'h40, 1'b0, 8'h00, 8'h01, 10};
    vecs[2]  = '{"lsr_imm", 16'h7081, 16'h0000, 8'h00, 1, 1, 1, 2'd1, 4'h7, 1'b1, 8'h81, 8'h00, 1'b0, 8'h00, 8'h01, 5};
    vecs[3]  = '{"lda_imm", 16'h803C, 16'h0000, 8'h00, 0, 1, 1, 2'd2, 4'h0, 1'b0, 8'h3C, 8'h00, 1'b0, 8'h00, 8'h01, 4};
    vecs[4]  = '{"lda_mem", 16'h8840, 16'hAB5A, 8'h00, 0, 2, 1, 2'd2, 4'h0, 1'b0, 8'h5A, 8'h40, 1'b0, 8'h00, 8'h01, 6};
    vecs[5]  = '{"jz_take", 16'hB020, 16'h0000, 8'h00, 0, 1, 0, 2'd0, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h20, 4};
    vecs[6]  = '{"jz_skip", 16'hB020, 16'h0000, 8'h07, 0, 1, 0, 2'd0, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h01, 4};
    vecs[7]  = '{"jmp",     16'hA033, 16'h0000, 8'h07, 0, 1, 0, 2'd0, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h33, 4};
    vecs[8]  = '{"sta",     16'h9010, 16'h0000, 8'hA5, 1, 2, 0, 2'd0, 4'h0, 1'b0, 8'h00, 8'h10, 1'b1, 8'hA5, 8'h01, 8};
    vecs[9]  = '{"nop_m1",  16'hC8FF, 16'h0000, 8'h00, 0, 1, 0, 2'd0, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h01, 4};
    vecs[10] = '{"and_rsv", 16'h2755, 16'h0000, 8'h00, 0, 1, 1, 2'd1, 4'h2, 1'b1, 8'h55, 8'h00, 1'b0, 8'h00, 8'h01, 4};
    vecs[11] = '{"mvn_mem", 16'h5840, 16'h00FF, 8'h00, 3, 2, 1, 2'd1, 4'h5, 1'b1, 8'hFF, 8'h40, 1'b0, 8'h00, 8'h01, 12};

    repeat (2) @(negedge clk);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset pc", 32'(pc), 32'd0);
    chk("reset halted", 32'(halted), 32'd0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Reset asserted asynchronously while the operand read is waiting.
    mem[0] = 16'h1840;
    wait_n = 3;
    do_reset();
    nrise = 0; cyc = 0; prev = 1'b0;
    while (nrise < 2 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mem_req && !prev) nrise++;
      prev = mem_req;
    end
    chk("owait reached", 32'(nrise), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("async rst outputs", {mem_req, mem_we, ctl_dev, ctl_opaddr, halted, 22'd0},
        32'd0);
    chk("async rst buses", {mem_addr, mem_wdata, sys_data, pc}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst req", 32'(mem_req), 32'd1);
    chk("post-rst addr", 32'(mem_addr), 32'd0);
    chk("post-rst pc", 32'(pc), 32'd0);

    // Jump to 0xFF, HLT there: PC wraps to 0 and no further requests appear.
    mem[0] = 16'hA0FF;
    mem[8'hFF] = 16'hF000;
    wait_n = 0;
`ifdef SEQ_STEP_EN
    step = 1'b0;
`endif
    do_reset();
`ifdef SEQ_STEP_EN
    repeat (5) @(negedge clk);
    chk("step low idle", 32'(mem_req), 32'd0);
    step = 1'b1;
`endif
    nrise = 0; prev = 1'b0; addr2 = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mem_req && !prev) begin
        nrise++;
        if (nrise == 2) addr2 = mem_addr;
      end
      prev = mem_req;
    end
    chk("halt request count", 32'(nrise), 32'd2);
    chk("halt fetch addr", 32'(addr2), 32'hFF);
    chk("halted", 32'(halted), 32'd1);
    chk("halt pc wrap", 32'(pc), 32'd0);
    chk("halt idle outputs", {mem_req, ctl_dev, ctl_opaddr}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
